laser_rx_lanes: RTL and testbench

Parametrised multi-lane optical receiver; the next generation of the two-lane fixed-8-bit laser receiver. Recovers lock-step frames from LANES photodiode inputs using a configurable oversampling ratio, 3-sample majority voting and start/stop framing checks. Delivers one word per lane through a valid/ready handshake with overrun and per-lane framing-error reporting. Sits between the photodiode pins and the receive FIFO / FT-interface logic.

---
 rtl/laser_rx_lanes.sv | 201 ++++++++++++++++++++
 tb/tb_laser_rx_lanes.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_rx_lanes.sv
// Multi-lane oversampled laser receiver: lanes share one framing FSM and sample counter,
// each lane majority-votes three mid-bit samples and delivers words via valid/ready.
module laser_rx_lanes #(
    parameter int LANES      = 2,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
    input  logic [LANES-1:0]             laser_in,
    output logic [LANES*DATA_BITS-1:0]   data_out,
    output logic                         data_valid,
    input  logic                         data_ready,
    output logic [LANES-1:0]             frame_err,
    output logic                         overrun,
    output logic                         busy
);

    localparam int MID   = OVERSAMPLE / 2;
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_VOTE_LO = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_VOTE_MD = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_VOTE_HI = CNT_W'(MID + 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t                       state_reg;
    state_t                       state_next;
    logic [LANES-1:0]             rx_meta_reg;
    logic [LANES-1:0]             rx_s_reg;
    logic [CNT_W-1:0]             sample_cnt_reg;
    logic [BIT_W-1:0]             bit_cnt_reg;
    logic [LANES-1:0]             bit_value;
    logic [LANES-1:0]             start_ok;
    logic [LANES*DATA_BITS-1:0]   shift_all;
    logic                         detect;
    logic                         bit_end;
    logic                         in_window;
    logic                         latch_start;
    logic                         shift_bit;
    logic                         load_frame;

    // Two-flop synchroniser on the raw photodiode levels
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_reg <= '0;
            rx_s_reg    <= '0;
        end else begin
            rx_meta_reg <= laser_in;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    assign detect    = (state_reg == IDLE) && en && (|rx_s_reg);
    assign bit_end   = (sample_cnt_reg == CNT_LAST);
    assign in_window = (state_reg != IDLE) &&
                       ((sample_cnt_reg == CNT_VOTE_LO) ||
                        (sample_cnt_reg == CNT_VOTE_MD) ||
                        (sample_cnt_reg == CNT_VOTE_HI));
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        latch_start = 1'b0;
        shift_bit   = 1'b0;
        load_frame  = 1'b0;
        if (!en) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|rx_s_reg) begin
                        state_next = START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        // A start bit seen on no lane at all is treated as line noise
                        if (|bit_value) begin
                            latch_start = 1'b1;
                            state_next  = DATA;
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift_bit = 1'b1;
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_next = STOP;
                        end
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        load_frame = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // The detect cycle counts as sample 0 of the start bit, hence the load of 1
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_cnt_reg <= '0;
            bit_cnt_reg    <= '0;
        end else if (state_reg == IDLE) begin
            sample_cnt_reg <= detect ? CNT_W'(1) : '0;
            bit_cnt_reg    <= '0;
        end else begin
            sample_cnt_reg <= bit_end ? '0 : sample_cnt_reg + 1'b1;
            if (shift_bit) begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [1:0]           vote_reg;
            logic [1:0]           vote_total;
            logic                 start_ok_reg;
            logic [DATA_BITS-1:0] lane_sr_reg;

            // Include the current sample so a window ending on the last count still counts
            assign vote_total     = vote_reg + {1'b0, in_window & rx_s_reg[gi]};
            assign bit_value[gi]  = vote_total[1];
            assign start_ok[gi]   = start_ok_reg;
            assign shift_all[gi*DATA_BITS +: DATA_BITS] = lane_sr_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    vote_reg <= '0;
                end else if ((state_reg == IDLE) || bit_end) begin
                    vote_reg <= '0;
                end else begin
                    vote_reg <= vote_total;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    start_ok_reg <= 1'b0;
                    lane_sr_reg  <= '0;
                end else begin
                    if (latch_start) begin
                        start_ok_reg <= bit_value[gi];
                    end
                    if (shift_bit) begin
                        lane_sr_reg                <= lane_sr_reg >> 1;
                        lane_sr_reg[DATA_BITS-1]   <= bit_value[gi];
                    end
                end
            end
        end
    endgenerate

    // A load that coincides with an accept replaces the word without flagging overrun
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= '0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load_frame) begin
                data_out   <= shift_all;
                frame_err  <= ~start_ok | bit_value;
                data_valid <= 1'b1;
                overrun    <= data_valid & ~data_ready;
            end else if (data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_laser_rx_lanes.sv
// Directed bench for laser_rx_lanes: default 2x8x8 instance plus a 4x5x5 instance for noisy voting.
module tb_laser_rx_lanes;

    logic        clock = 1'b0;
    logic        reset;
    logic        en;
    logic        data_ready;
    logic [1:0]  laser_a;
    logic [15:0] data_a;
    logic        valid_a;
    logic [1:0]  ferr_a;
    logic        ovr_a;
    logic        busy_a;
    logic [3:0]  laser_b;
    logic [19:0] data_b;
    logic        valid_b;
    logic [3:0]  ferr_b;
    logic        ovr_b;
    logic        busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    laser_rx_lanes dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .laser_in   (laser_a),
        .data_out   (data_a),
        .data_valid (valid_a),
        .data_ready (data_ready),
        .frame_err  (ferr_a),
        .overrun    (ovr_a),
        .busy       (busy_a)
    );

    laser_rx_lanes #(.LANES(4), .DATA_BITS(5), .OVERSAMPLE(5)) dut_wide (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .laser_in   (laser_b),
        .data_out   (data_b),
        .data_valid (valid_b),
        .data_ready (data_ready),
        .frame_err  (ferr_b),
        .overrun    (ovr_b),
        .busy       (busy_b)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Caller sits just after a posedge; returns just after the posedge that ends the stop bit
    task automatic send_frame(input logic [15:0] word, input logic [1:0] start_bits,
                              input logic [1:0] stop_bits);
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (k == 0)      laser_a[i] = start_bits[i];
                else if (k == 9) laser_a[i] = stop_bits[i];
                else             laser_a[i] = word[i*8 + k - 1];
            end
            repeat (8) step();
        end
        laser_a = 2'b00;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; data_ready = 1'b0; laser_a = '0; laser_b = '0;
        repeat (3) step();
        @(negedge clock);
        checks++; if (data_a !== 16'h0000) begin errors++; $display("FAIL reset_data got %h want 0000", data_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_a); end
        checks++; if (ferr_a !== 2'b00) begin errors++; $display("FAIL reset_ferr got %b want 00", ferr_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", ovr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_a); end
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_wide got %b want 0", valid_b); end
        step();
        reset = 1'b0;
        repeat (2) step();
        $display("reset: outputs idle");
    endtask

    task automatic test_default();
        data_ready = 1'b1;
        step();
        send_frame(16'h3CA5, 2'b11, 2'b00);
        step();
        @(negedge clock);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL default_early_valid got %b want 0", valid_a); end
        step();
        @(negedge clock);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL default_valid got %b want 1", valid_a); end
        checks++; if (data_a !== 16'h3CA5) begin errors++; $display("FAIL default_data got %h want 3ca5", data_a); end
        checks++; if (ferr_a !== 2'b00) begin errors++; $display("FAIL default_ferr got %b want 00", ferr_a); end
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL default_overrun got %b want 0", ovr_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL default_busy got %b want 0", busy_a); end
        step();
        @(negedge clock);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL default_consumed got %b want 0", valid_a); end
        $display("default: frame data=%h err=%b", data_a, ferr_a);
    endtask

    task automatic test_glitch();
        int seen;
        seen = 0;
        step();
        laser_a = 2'b01;
        repeat (3) step();
        laser_a = 2'b00;
        @(negedge clock);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL glitch_busy_d1 got %b want 1", busy_a); end
        repeat (6) step();
        @(negedge clock);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL glitch_busy_d7 got %b want 1", busy_a); end
        step();
        @(negedge clock);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL glitch_busy_d8 got %b want 0", busy_a); end
        repeat (90) begin
            step();
            @(negedge clock);
            if (valid_a) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL glitch_no_output got %0d valid cycles want 0", seen); end
        $display("glitch: aborted, valid cycles=%0d", seen);
    endtask

    task automatic test_frame_err();
        data_ready = 1'b1;
        step();
        send_frame(16'h5A0F, 2'b10, 2'b10);
        repeat (2) step();
        @(negedge clock);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL ferr_valid got %b want 1", valid_a); end
        checks++; if (data_a !== 16'h5A0F) begin errors++; $display("FAIL ferr_data got %h want 5a0f", data_a); end
        checks++; if (ferr_a !== 2'b11) begin errors++; $display("FAIL ferr_flags got %b want 11", ferr_a); end
        $display("frame_err: frame data=%h err=%b", data_a, ferr_a);
    endtask

    task automatic test_back_to_back();
        data_ready = 1'b0;
        step();
        send_frame(16'h1122, 2'b11, 2'b00);
        send_frame(16'h3344, 2'b11, 2'b00);
        step();
        @(negedge clock);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL b2b_first_valid got %b want 1", valid_a); end
        checks++; if (data_a !== 16'h1122) begin errors++; $display("FAIL b2b_first_data got %h want 1122", data_a); end
        step();
        @(negedge clock);
        checks++; if (data_a !== 16'h3344) begin errors++; $display("FAIL b2b_second_data got %h want 3344", data_a); end
        checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", ovr_a); end
        step();
        @(negedge clock);
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL b2b_overrun_pulse got %b want 0", ovr_a); end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL b2b_hold_valid got %b want 1", valid_a); end
        $display("back_to_back: overwrite data=%h", data_a);
        step();
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        @(negedge clock);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", valid_a); end
        step();
        send_frame(16'h5566, 2'b11, 2'b00);
        send_frame(16'h7788, 2'b11, 2'b00);
        step();
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        @(negedge clock);
        checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL b2b_accept_overrun got %b want 0", ovr_a); end
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL b2b_accept_valid got %b want 1", valid_a); end
        checks++; if (data_a !== 16'h7788) begin errors++; $display("FAIL b2b_accept_data got %h want 7788", data_a); end
        $display("back_to_back: accept+load data=%h", data_a);
    endtask

    task automatic test_reset_midframe();
        step();
        laser_a = 2'b11;
        repeat (42) step();
        reset = 1'b1;
        laser_a = 2'b00;
        #1;
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", valid_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy_a); end
        checks++; if (data_a !== 16'h0000) begin errors++; $display("FAIL midreset_data got %h want 0000", data_a); end
        checks++; if (ferr_a !== 2'b00) begin errors++; $display("FAIL midreset_ferr got %b want 00", ferr_a); end
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();
        data_ready = 1'b1;
        send_frame(16'h7E81, 2'b11, 2'b00);
        step();
        @(negedge clock);
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL midreset_early got %b want 0", valid_a); end
        step();
        @(negedge clock);
        checks++; if (valid_a !== 1'b1) begin errors++; $display("FAIL midreset_new_valid got %b want 1", valid_a); end
        checks++; if (data_a !== 16'h7E81) begin errors++; $display("FAIL midreset_new_data got %h want 7e81", data_a); end
        checks++; if (ferr_a !== 2'b00) begin errors++; $display("FAIL midreset_new_ferr got %b want 00", ferr_a); end
        $display("reset_midframe: frame data=%h err=%b", data_a, ferr_a);
    endtask

    task automatic test_enable();
        int seen;
        seen = 0;
        step();
        laser_a = 2'b11;
        repeat (20) step();
        @(negedge clock);
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL enable_busy_before got %b want 1", busy_a); end
        step();
        en = 1'b0;
        laser_a = 2'b00;
        step();
        @(negedge clock);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL enable_busy_after got %b want 0", busy_a); end
        step();
        en = 1'b1;
        repeat (90) begin
            step();
            @(negedge clock);
            if (valid_a) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL enable_discard got %0d valid cycles want 0", seen); end
        $display("enable: partial frame discarded");
    endtask

    task automatic test_wide_noise();
        logic [19:0] payload;
        logic        b;
        payload = {5'h03, 5'h1F, 5'h0A, 5'h15};
        data_ready = 1'b1;
        step();
        for (int k = 0; k < 7; k++) begin
            for (int c = 0; c < 5; c++) begin
                for (int i = 0; i < 4; i++) begin
                    if (k == 0)      b = 1'b1;
                    else if (k == 6) b = 1'b0;
                    else             b = payload[i*5 + k - 1];
                    laser_b[i] = b ^ (c == 2);
                end
                step();
            end
        end
        laser_b = 4'h0;
        step();
        @(negedge clock);
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL wide_early got %b want 0", valid_b); end
        step();
        @(negedge clock);
        checks++; if (valid_b !== 1'b1) begin errors++; $display("FAIL wide_valid got %b want 1", valid_b); end
        checks++; if (data_b !== 20'h1FD55) begin errors++; $display("FAIL wide_data got %h want 1fd55", data_b); end
        checks++; if (ferr_b !== 4'h0) begin errors++; $display("FAIL wide_ferr got %b want 0000", ferr_b); end
        $display("wide_noise: frame data=%h err=%b", data_b, ferr_b);
    endtask

    initial begin
        test_reset();
        test_default();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
        test_enable();
        test_wide_noise();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
